// File: rtl/cmd_pkg.sv
// Shared definitions for the command interface response path.
//   - Command codes recognised by the parser, echoed back as ACK values.
//   - NO_MATCH_POS: byte position reported when no match exists.
//   - tx_state_e: per-byte transmit handshake states (IDLE/SEND/HOLD/WAIT).
package cmd_pkg;

  localparam logic [7:0]  CMD_SET_HASH   = 8'h01;
  localparam logic [7:0]  CMD_SEND_TEXT  = 8'h02;
  localparam logic [7:0]  CMD_READ_MATCH = 8'h03;

  localparam logic [15:0] NO_MATCH_POS   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2,
    ST_WAIT = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tx_byte_pacer.sv
// Byte pacer: issues one byte to uart_tx per go request using the
// SEND -> HOLD -> WAIT handshake.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   go_i, byte_i   start a byte (accepted in IDLE, or in WAIT once the UART
//                  is free, so back-to-back bytes need no IDLE cycle)
//   txd_busy_i     uart_tx busy
//   txd_start_o    one-cycle start pulse (state SEND)
//   txd_data_o     byte to transmit; holds its value outside SEND
//   byte_done_o    WAIT sees txd_busy low: the current byte has completed
//   idle_o         pacer is in IDLE
module tx_byte_pacer
  import cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       go_i,
  input  logic [7:0] byte_i,
  input  logic       txd_busy_i,
  output logic       txd_start_o,
  output logic [7:0] txd_data_o,
  output logic       byte_done_o,
  output logic       idle_o
);

  tx_state_e  state_q;
  logic [7:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go_i) begin
            state_q <= ST_SEND;
            data_q  <= byte_i;
          end
        end
        ST_SEND: state_q <= ST_HOLD;
        // Guard cycle: gives uart_tx time to raise txd_busy.
        ST_HOLD: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (!txd_busy_i) begin
            if (go_i) begin
              state_q <= ST_SEND;
              data_q  <= byte_i;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign txd_start_o = (state_q == ST_SEND);
  assign txd_data_o  = data_q;
  assign byte_done_o = (state_q == ST_WAIT) && !txd_busy_i;
  assign idle_o      = (state_q == ST_IDLE);

endmodule

// File: rtl/match_tx.sv
// match_tx: response serializer for the command interface.
// Sends single-byte ACKs, or the match record (2-byte big-endian byte
// position followed by STR_LEN string bytes, first character first) to the
// uart_tx byte port, pacing bytes with txd_start/txd_busy.
// Configuration macro: MATCH_TX_CKSUM_EN -- when defined, the match record
// carries a trailing XOR checksum byte over all preceding record bytes.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   ack_req, ack_code     send one ACK byte (accepted when ready=1)
//   match_req             send the match record (accepted when ready=1)
//   match_valid, byte_pos, match_str   record fields, sampled at acceptance
//   txd_busy              uart_tx busy
//   txd_start, txd_data   byte strobe / data to uart_tx
//   ready                 idle and able to accept a request
//   done                  one-cycle pulse when the last byte has completed
module match_tx
  import cmd_pkg::*;
#(
  parameter int STR_LEN = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ack_req,
  input  logic [7:0]           ack_code,
  input  logic                 match_req,
  input  logic                 match_valid,
  input  logic [15:0]          byte_pos,
  input  logic [8*STR_LEN-1:0] match_str,
  input  logic                 txd_busy,
  output logic                 txd_start,
  output logic [7:0]           txd_data,
  output logic                 ready,
  output logic                 done
);

  localparam int CW = $clog2(STR_LEN + 4);
`ifdef MATCH_TX_CKSUM_EN
  localparam int REC_BYTES = STR_LEN + 3;
`else
  localparam int REC_BYTES = STR_LEN + 2;
`endif
  localparam int RW = REC_BYTES * 8;

  // Record fields after no-match substitution.
  logic [15:0]          pos_eff;
  logic [8*STR_LEN-1:0] str_eff;
  logic [RW-1:0]        rec;

  assign pos_eff = match_valid ? byte_pos  : NO_MATCH_POS;
  assign str_eff = match_valid ? match_str : '0;

`ifdef MATCH_TX_CKSUM_EN
  // XOR chain over position bytes then each string byte.
  logic [7:0] xor_chain [0:STR_LEN];
  assign xor_chain[0] = pos_eff[15:8] ^ pos_eff[7:0];
  generate
    for (genvar gi = 0; gi < STR_LEN; gi++) begin : g_cksum
      assign xor_chain[gi+1] = xor_chain[gi] ^ str_eff[gi*8 +: 8];
    end
  endgenerate
  assign rec = {pos_eff, str_eff, xor_chain[STR_LEN]};
`else
  assign rec = {pos_eff, str_eff};
`endif

  logic [RW-1:0] sr_q;     // remaining bytes, head in the MSByte
  logic [CW-1:0] count_q;  // bytes still to send after the one in flight

  logic       pacer_idle;
  logic       byte_done;
  logic       accept_ack;
  logic       accept_match;
  logic       more_bytes;
  logic       go;
  logic [7:0] head_byte;

  assign accept_ack   = pacer_idle && ack_req;
  // ACK wins a simultaneous request; the match request is simply dropped.
  assign accept_match = pacer_idle && match_req && !ack_req;
  assign more_bytes   = (count_q != '0);
  assign go           = accept_ack || accept_match || (byte_done && more_bytes);

  // On acceptance the first byte goes straight to the pacer, so the
  // shift register only ever holds what is left to send.
  always_comb begin
    head_byte = sr_q[RW-1 -: 8];
    if (accept_ack) begin
      head_byte = ack_code;
    end else if (accept_match) begin
      head_byte = rec[RW-1 -: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      count_q <= '0;
    end else if (accept_ack) begin
      count_q <= '0;
    end else if (accept_match) begin
      sr_q    <= rec << 8;
      count_q <= CW'(REC_BYTES - 1);
    end else if (byte_done && more_bytes) begin
      sr_q    <= sr_q << 8;
      count_q <= count_q - CW'(1);
    end
  end

  tx_byte_pacer u_pacer (
    .clk         (clk),
    .reset       (reset),
    .go_i        (go),
    .byte_i      (head_byte),
    .txd_busy_i  (txd_busy),
    .txd_start_o (txd_start),
    .txd_data_o  (txd_data),
    .byte_done_o (byte_done),
    .idle_o      (pacer_idle)
  );

  assign ready = pacer_idle;
  assign done  = byte_done && !more_bytes;

endmodule

// File: tb/tb_match_tx.sv
module tb_match_tx;

  localparam int STR_LEN = 19;
  localparam int NV      = 7;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 ack_req;
  logic [7:0]           ack_code;
  logic                 match_req;
  logic                 match_valid;
  logic [15:0]          byte_pos;
  logic [8*STR_LEN-1:0] match_str;
  logic                 txd_busy;
  logic                 txd_start;
  logic [7:0]           txd_data;
  logic                 ready;
  logic                 done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  match_tx #(.STR_LEN(STR_LEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .ack_req     (ack_req),
    .ack_code    (ack_code),
    .match_req   (match_req),
    .match_valid (match_valid),
    .byte_pos    (byte_pos),
    .match_str   (match_str),
    .txd_busy    (txd_busy),
    .txd_start   (txd_start),
    .txd_data    (txd_data),
    .ready       (ready),
    .done        (done)
  );

  typedef struct {
    logic                 a_req;
    logic [7:0]           a_code;
    logic                 m_req;
    logic                 m_valid;
    logic [15:0]          pos;
    logic [8*STR_LEN-1:0] str;
    int                   busy;    // busy cycles after each txd_start
    int                   nbytes;  // expected bytes, excluding checksum
    logic [183:0]         exp;     // expected bytes, first byte in MSByte
    logic                 intrude; // pulse match_req mid-response
  } vec_t;

  vec_t tbl [0:NV-1];

  function automatic vec_t mk(input logic a, input logic [7:0] ac, input logic m,
                              input logic mv, input logic [15:0] p,
                              input logic [8*STR_LEN-1:0] s, input int b,
                              input int n, input logic [183:0] e, input logic intr);
    vec_t v;
    v.a_req = a; v.a_code = ac; v.m_req = m; v.m_valid = mv; v.pos = p;
    v.str = s; v.busy = b; v.nbytes = n; v.exp = e; v.intrude = intr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic run_vec(input int idx);
    vec_t       t;
    int         n, got, last_start, done_c, rem, b, extra;
    logic [7:0] eb [0:23];
    logic [7:0] x;
    t = tbl[idx];
    n = t.nbytes;
    b = t.busy;
    for (int k = 0; k < 23; k++) eb[k] = t.exp[183 - 8*k -: 8];
    eb[23] = 8'h00;
`ifdef MATCH_TX_CKSUM_EN
    if (t.m_req && !t.a_req) begin
      x = 8'h00;
      for (int k = 0; k < n; k++) x = x ^ eb[k];
      eb[n] = x;
      n++;
    end
`endif
    @(negedge clk);
    chk($sformatf("v%0d_ready_pre", idx), 32'(ready), 32'd1);
    ack_req = t.a_req; ack_code = t.a_code; match_req = t.m_req;
    match_valid = t.m_valid; byte_pos = t.pos; match_str = t.str;
    @(negedge clk);
    // Scramble inputs after acceptance: the response must use the snapshot.
    ack_req = 1'b0; match_req = 1'b0;
    ack_code = ~t.a_code; byte_pos = ~t.pos; match_str = ~t.str; match_valid = ~t.m_valid;
    got = 0; last_start = -1; done_c = -1; rem = 0;
    for (int c = 1; c <= 600 && done_c < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (rem > 0) begin txd_busy = 1'b1; rem--; end else txd_busy = 1'b0;
      if (t.intrude && c == 3) begin match_req = 1'b1; match_valid = 1'b1; end
      if (t.intrude && c == 4) match_req = 1'b0;
      #1;
      if (txd_start) begin
        if (got < n) begin
          chk($sformatf("v%0d_byte%0d", idx, got), 32'(txd_data), 32'(eb[got]));
          chk($sformatf("v%0d_start%0d_cycle", idx, got), c,
              (got == 0) ? 1 : last_start + imax(3, b + 2));
        end
        got++;
        last_start = c;
        rem = b;
      end
      if (done) done_c = c;
    end
    txd_busy = 1'b0;
    chk($sformatf("v%0d_nbytes", idx), got, n);
    chk($sformatf("v%0d_done_cycle", idx), done_c, last_start + imax(2, b + 1));
    @(negedge clk); #1;
    chk($sformatf("v%0d_ready_post", idx), 32'(ready), 32'd1);
    chk($sformatf("v%0d_done_single", idx), 32'(done), 32'd0);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (txd_start || done) extra++;
    end
    chk($sformatf("v%0d_quiet_after", idx), extra, 0);
    $display("vec %0d: %0d bytes sent (expected %0d), done at cycle %0d, busy=%0d",
             idx, got, n, done_c, b);
  endtask

  initial begin
    int seen, extra;
    logic [8*STR_LEN-1:0] s_fox, s_abc, s_num;
    s_fox = "The quick brown fox";
    s_abc = "ABCDEFGHIJKLMNOPQRS";
    s_num = "0123456789abcdefghi";

    tbl[0] = mk(1'b1, 8'h01, 1'b0, 1'b0, 16'h0000, '0, 0, 1, {8'h01, 176'h0}, 1'b0);
    tbl[1] = mk(1'b1, 8'h02, 1'b0, 1'b0, 16'h0000, '0, 3, 1, {8'h02, 176'h0}, 1'b1);
    tbl[2] = mk(1'b0, 8'h00, 1'b1, 1'b1, 16'h0007, s_fox, 0, 21,
                {8'h00, 8'h07, 8'h54, 8'h68, 8'h65, 8'h20, 8'h71, 8'h75, 8'h69, 8'h63,
                 8'h6B, 8'h20, 8'h62, 8'h72, 8'h6F, 8'h77, 8'h6E, 8'h20, 8'h66, 8'h6F,
                 8'h78, 16'h0}, 1'b0);
    tbl[3] = mk(1'b0, 8'h00, 1'b1, 1'b0, 16'hABCD, s_abc, 0, 21,
                {16'hFFFF, 152'h0, 16'h0}, 1'b0);
    tbl[4] = mk(1'b0, 8'h00, 1'b1, 1'b1, 16'h1234, s_abc, 10, 21,
                {8'h12, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48,
                 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F, 8'h50, 8'h51, 8'h52,
                 8'h53, 16'h0}, 1'b0);
    tbl[5] = mk(1'b1, 8'h5A, 1'b1, 1'b1, 16'h0007, s_fox, 0, 1, {8'h5A, 176'h0}, 1'b0);
    tbl[6] = mk(1'b0, 8'h00, 1'b1, 1'b1, 16'hBEEF, s_num, 1, 21,
                {8'hBE, 8'hEF, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                 8'h38, 8'h39, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68,
                 8'h69, 16'h0}, 1'b0);

    reset = 1'b1; ack_req = 1'b0; ack_code = 8'h00; match_req = 1'b0;
    match_valid = 1'b0; byte_pos = 16'h0; match_str = '0; txd_busy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_txd_start", 32'(txd_start), 32'd0);
    chk("reset_txd_data",  32'(txd_data),  32'd0);
    chk("reset_ready",     32'(ready),     32'd1);
    chk("reset_done",      32'(done),      32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset mid-response, after the fifth byte has started.
    @(negedge clk);
    match_req = 1'b1; match_valid = 1'b1; byte_pos = 16'h1234; match_str = s_abc;
    @(negedge clk);
    match_req = 1'b0;
    seen = 0;
    for (int c = 1; c <= 100 && seen < 5; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      if (txd_start) seen++;
    end
    chk("rst_mid_bytes_before", seen, 5);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid_txd_start", 32'(txd_start), 32'd0);
    chk("rst_mid_done",      32'(done),      32'd0);
    chk("rst_mid_ready",     32'(ready),     32'd1);
    chk("rst_mid_txd_data",  32'(txd_data),  32'd0);
    reset = 1'b0;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (txd_start || done) extra++;
    end
    chk("rst_mid_quiet", extra, 0);
    $display("reset mid-response: %0d bytes sent before reset, %0d events after", seen, extra);
    run_vec(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
